// File: rtl/counter_access_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : counter_access_unit_if
//  Purpose  : 8254 counter bus: chip select, strobes, address and data lines
//  Revision : 1.0  initial release
// ============================================================================
interface counter_access_unit_if;
    logic       cs;
    logic       wr;
    logic       rd;
    logic [1:0] a;
    logic [7:0] din;
    logic [7:0] dout;

    modport master (output cs, wr, rd, a, din, input dout);
    modport slave  (input cs, wr, rd, a, din, output dout);
endinterface
`default_nettype wire

// File: rtl/counter_access_unit.sv
`default_nettype none
// ============================================================================
//  Module   : counter_access_unit
//  Purpose  : per-counter control-word decode, count assembly and count
//             read-back (live or latched) in front of the 8254 mode unit
//  Revision : 1.0  initial release
// ============================================================================
module counter_access_unit #(
    parameter int COUNTER_ID = 0
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    counter_access_unit_if.slave      bus,
    input  wire logic [15:0]          current_count,
    output logic      [15:0]          countreg,
    output logic                      new_count,
    output logic      [2:0]           mode,
    output logic                      bcd,
    output logic                      count_pending
);

    localparam logic [1:0] C_ID     = COUNTER_ID[1:0];
    localparam logic [1:0] C_RW_LSB = 2'b01;
    localparam logic [1:0] C_RW_MSB = 2'b10;

    logic [1:0]  r_rw;
    logic        r_wr_msb;
    logic        r_rd_msb;
    logic        r_latched;
    logic [15:0] r_latch;
    logic [7:0]  r_hold;
    logic [7:0]  r_dout;

    logic        w_wr_en;
    logic        w_rd_en;
    logic        w_ctrl;
    logic        w_cnt_sel;
    logic [15:0] w_src;
    logic [2:0]  w_mode;

    // A simultaneous read is dropped in favour of the write.
    assign w_wr_en   = bus.cs & bus.wr;
    assign w_rd_en   = bus.cs & bus.rd & ~bus.wr;
    assign w_ctrl    = (bus.a == 2'd3) && (bus.din[7:6] == C_ID);
    assign w_cnt_sel = (bus.a == C_ID);
    assign w_src     = r_latched ? r_latch : current_count;
    // Modes 6 and 7 alias to 2 and 3.
    assign w_mode    = (bus.din[3:2] == 2'b11) ? {1'b0, bus.din[2:1]} : bus.din[3:1];
    assign bus.dout  = r_dout;

    // Bus access state: control word, count assembly, read pointer and latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rw          <= 2'b11;
            r_wr_msb      <= 1'b0;
            r_rd_msb      <= 1'b0;
            r_latched     <= 1'b0;
            r_latch       <= 16'h0000;
            r_hold        <= 8'h00;
            r_dout        <= 8'h00;
            countreg      <= 16'h0000;
            new_count     <= 1'b0;
            mode          <= 3'd0;
            bcd           <= 1'b0;
            count_pending <= 1'b0;
        end else begin
            new_count <= 1'b0;
            if (w_wr_en && w_ctrl) begin
                if (bus.din[5:4] == 2'b00) begin
                    if (!r_latched) begin
                        r_latch   <= current_count;
                        r_latched <= 1'b1;
                    end
                end else begin
                    r_rw          <= bus.din[5:4];
                    mode          <= w_mode;
                    bcd           <= bus.din[0];
                    r_wr_msb      <= 1'b0;
                    r_rd_msb      <= 1'b0;
                    r_latched     <= 1'b0;
                    count_pending <= 1'b1;
                end
            end else if (w_wr_en && w_cnt_sel) begin
                if (r_rw == C_RW_LSB) begin
                    countreg      <= {8'h00, bus.din};
                    new_count     <= 1'b1;
                    count_pending <= 1'b0;
                end else if (r_rw == C_RW_MSB) begin
                    countreg      <= {bus.din, 8'h00};
                    new_count     <= 1'b1;
                    count_pending <= 1'b0;
                end else if (!r_wr_msb) begin
                    r_hold   <= bus.din;
                    r_wr_msb <= 1'b1;
                end else begin
                    countreg      <= {bus.din, r_hold};
                    new_count     <= 1'b1;
                    count_pending <= 1'b0;
                    r_wr_msb      <= 1'b0;
                end
            end else if (w_rd_en && w_cnt_sel) begin
                if (r_rw == C_RW_LSB) begin
                    r_dout    <= w_src[7:0];
                    r_latched <= 1'b0;
                end else if (r_rw == C_RW_MSB) begin
                    r_dout    <= w_src[15:8];
                    r_latched <= 1'b0;
                end else begin
                    r_dout   <= r_rd_msb ? w_src[15:8] : w_src[7:0];
                    r_rd_msb <= ~r_rd_msb;
                    if (r_rd_msb) begin
                        r_latched <= 1'b0;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_counter_access_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_counter_access_unit
//  Purpose  : directed vector bench for counter_access_unit (IDs 0 and 1)
//  Revision : 1.0  initial release
// ============================================================================
module tb_counter_access_unit;

    logic        clk;
    logic        rst_n;
    logic        cs, wr, rd;
    logic [1:0]  a;
    logic [7:0]  din;
    logic [15:0] cur;

    logic [15:0] countreg0, countreg1;
    logic        new_count0, new_count1;
    logic [2:0]  mode0, mode1;
    logic        bcd0, bcd1;
    logic        pend0, pend1;

    int passed;
    int total;

    counter_access_unit_if bus0 ();
    counter_access_unit_if bus1 ();

    assign bus0.cs = cs;  assign bus1.cs = cs;
    assign bus0.wr = wr;  assign bus1.wr = wr;
    assign bus0.rd = rd;  assign bus1.rd = rd;
    assign bus0.a  = a;   assign bus1.a  = a;
    assign bus0.din = din; assign bus1.din = din;

    counter_access_unit #(.COUNTER_ID(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0.slave), .current_count(cur),
        .countreg(countreg0), .new_count(new_count0), .mode(mode0),
        .bcd(bcd0), .count_pending(pend0)
    );

    counter_access_unit #(.COUNTER_ID(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1.slave), .current_count(cur),
        .countreg(countreg1), .new_count(new_count1), .mode(mode1),
        .bcd(bcd1), .count_pending(pend1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        cs, wr, rd;
        logic [1:0]  a;
        logic [7:0]  din;
        logic [15:0] cur;
        logic [15:0] e_countreg;
        logic        e_nc;
        logic [7:0]  e_dout;
        logic [2:0]  e_mode;
        logic        e_bcd;
        logic        e_pend;
    } vec_t;

    vec_t vecs[20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic apply(input logic c, input logic w, input logic r, input logic [1:0] ad,
                         input logic [7:0] d, input logic [15:0] cc);
        cs = c; wr = w; rd = r; a = ad; din = d; cur = cc;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_id1(input int idx);
        chk($sformatf("id1_countreg[%0d]", idx), {16'h0, countreg1}, 32'h0);
        chk($sformatf("id1_new_count[%0d]", idx), {31'h0, new_count1}, 32'h0);
        chk($sformatf("id1_mode[%0d]", idx), {29'h0, mode1}, 32'h0);
        chk($sformatf("id1_pending[%0d]", idx), {31'h0, pend1}, 32'h0);
    endtask

    initial begin
        passed = 0;
        total  = 0;
        //          cs   wr   rd   a     din    cur       countreg  nc   dout   mode bcd  pend
        vecs[0]  = '{1'b0,1'b0,1'b0,2'd0,8'h00,16'h0000, 16'h0000,1'b0,8'h00,3'd0,1'b0,1'b0};
        vecs[1]  = '{1'b1,1'b1,1'b0,2'd3,8'h12,16'h0000, 16'h0000,1'b0,8'h00,3'd1,1'b0,1'b1};
        vecs[2]  = '{1'b1,1'b1,1'b0,2'd0,8'h04,16'h0000, 16'h0004,1'b1,8'h00,3'd1,1'b0,1'b0};
        vecs[3]  = '{1'b0,1'b0,1'b0,2'd0,8'h00,16'h0000, 16'h0004,1'b0,8'h00,3'd1,1'b0,1'b0};
        vecs[4]  = '{1'b1,1'b1,1'b0,2'd3,8'h30,16'h0000, 16'h0004,1'b0,8'h00,3'd0,1'b0,1'b1};
        vecs[5]  = '{1'b1,1'b1,1'b0,2'd0,8'h34,16'h0000, 16'h0004,1'b0,8'h00,3'd0,1'b0,1'b1};
        vecs[6]  = '{1'b1,1'b1,1'b0,2'd0,8'h12,16'h0000, 16'h1234,1'b1,8'h00,3'd0,1'b0,1'b0};
        vecs[7]  = '{1'b1,1'b1,1'b0,2'd1,8'h99,16'h0000, 16'h1234,1'b0,8'h00,3'd0,1'b0,1'b0};
        vecs[8]  = '{1'b1,1'b1,1'b0,2'd3,8'h92,16'h0000, 16'h1234,1'b0,8'h00,3'd0,1'b0,1'b0};
        vecs[9]  = '{1'b1,1'b1,1'b0,2'd3,8'h00,16'hABCD, 16'h1234,1'b0,8'h00,3'd0,1'b0,1'b0};
        vecs[10] = '{1'b1,1'b0,1'b1,2'd0,8'h00,16'h0001, 16'h1234,1'b0,8'hCD,3'd0,1'b0,1'b0};
        vecs[11] = '{1'b1,1'b0,1'b1,2'd0,8'h00,16'h0001, 16'h1234,1'b0,8'hAB,3'd0,1'b0,1'b0};
        vecs[12] = '{1'b1,1'b0,1'b1,2'd0,8'h00,16'h0001, 16'h1234,1'b0,8'h01,3'd0,1'b0,1'b0};
        vecs[13] = '{1'b1,1'b0,1'b1,2'd0,8'h00,16'h0001, 16'h1234,1'b0,8'h00,3'd0,1'b0,1'b0};
        vecs[14] = '{1'b1,1'b1,1'b0,2'd3,8'h1F,16'h0001, 16'h1234,1'b0,8'h00,3'd3,1'b1,1'b1};
        vecs[15] = '{1'b1,1'b1,1'b0,2'd3,8'h1C,16'h0001, 16'h1234,1'b0,8'h00,3'd2,1'b0,1'b1};
        vecs[16] = '{1'b1,1'b1,1'b0,2'd3,8'h12,16'h0001, 16'h1234,1'b0,8'h00,3'd1,1'b0,1'b1};
        vecs[17] = '{1'b1,1'b0,1'b1,2'd0,8'h00,16'h00A5, 16'h1234,1'b0,8'hA5,3'd1,1'b0,1'b1};
        vecs[18] = '{1'b1,1'b1,1'b1,2'd0,8'h07,16'h0033, 16'h0007,1'b1,8'hA5,3'd1,1'b0,1'b0};
        vecs[19] = '{1'b0,1'b0,1'b0,2'd0,8'h00,16'h0033, 16'h0007,1'b0,8'hA5,3'd1,1'b0,1'b0};

        cs = 0; wr = 0; rd = 0; a = 0; din = 0; cur = 0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            apply(vecs[i].cs, vecs[i].wr, vecs[i].rd, vecs[i].a, vecs[i].din, vecs[i].cur);
            chk($sformatf("countreg[%0d]", i), {16'h0, countreg0}, {16'h0, vecs[i].e_countreg});
            chk($sformatf("new_count[%0d]", i), {31'h0, new_count0}, {31'h0, vecs[i].e_nc});
            chk($sformatf("dout[%0d]", i), {24'h0, bus0.dout}, {24'h0, vecs[i].e_dout});
            chk($sformatf("mode[%0d]", i), {29'h0, mode0}, {29'h0, vecs[i].e_mode});
            chk($sformatf("bcd[%0d]", i), {31'h0, bcd0}, {31'h0, vecs[i].e_bcd});
            chk($sformatf("pending[%0d]", i), {31'h0, pend0}, {31'h0, vecs[i].e_pend});
            chk_id1(i);
        end

        // A second latch command while latched must not refresh the latch.
        apply(1'b1, 1'b1, 1'b0, 2'd3, 8'h30, 16'h0000);
        apply(1'b1, 1'b1, 1'b0, 2'd3, 8'h00, 16'h1111);
        apply(1'b1, 1'b1, 1'b0, 2'd3, 8'h00, 16'h2222);
        apply(1'b1, 1'b0, 1'b1, 2'd0, 8'h00, 16'h3333);
        chk("relatch_lsb", {24'h0, bus0.dout}, 32'h11);
        apply(1'b1, 1'b0, 1'b1, 2'd0, 8'h00, 16'h3333);
        chk("relatch_msb", {24'h0, bus0.dout}, 32'h11);
        apply(1'b1, 1'b0, 1'b1, 2'd0, 8'h00, 16'h3333);
        chk("relatch_live", {24'h0, bus0.dout}, 32'h33);

        // Reset with an LSB held must clear everything at once.
        apply(1'b1, 1'b1, 1'b0, 2'd3, 8'h37, 16'h0000);
        chk("pre_rst_mode", {29'h0, mode0}, 32'd3);
        apply(1'b1, 1'b1, 1'b0, 2'd0, 8'hFF, 16'h0000);
        chk("held_no_pulse", {31'h0, new_count0}, 32'h0);
        cs = 1'b0; wr = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_countreg", {16'h0, countreg0}, 32'h0);
        chk("rst_new_count", {31'h0, new_count0}, 32'h0);
        chk("rst_dout", {24'h0, bus0.dout}, 32'h0);
        chk("rst_mode", {29'h0, mode0}, 32'h0);
        chk("rst_bcd", {31'h0, bcd0}, 32'h0);
        chk("rst_pending", {31'h0, pend0}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        apply(1'b1, 1'b1, 1'b0, 2'd0, 8'h05, 16'h0000);
        chk("post_rst_lsb_countreg", {16'h0, countreg0}, 32'h0);
        chk("post_rst_lsb_nc", {31'h0, new_count0}, 32'h0);
        apply(1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 16'h0000);
        chk("post_rst_countreg", {16'h0, countreg0}, 32'h0005);
        chk("post_rst_nc", {31'h0, new_count0}, 32'h1);
        cs = 1'b0; wr = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_nc_drop", {31'h0, new_count0}, 32'h0);
        chk_id1(99);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/counter_access_unit.md
# counter_access_unit

Per-counter read/write front end of the 8254 model, directly upstream of the mode units (`modeOne` and siblings). Decodes control words addressed to its counter, assembles the 8-bit bus writes into the 16-bit `countreg` value with a one-cycle `new_count` strobe, and serves bus reads of the live or latched count from the mode unit. One instance exists per counter, selected by `COUNTER_ID`.

## Interface
- `COUNTER_ID`, default 0: counter index (0-2), matched against `a` and the control-word SC field.
- `clk` input 1: system clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `cs` input 1: chip select, active high.
- `wr` input 1: write strobe, active high, sampled on `clk` when `cs`=1.
- `rd` input 1: read strobe, active high, sampled on `clk` when `cs`=1.
- `a` input 2: register address; 0-2 select count registers, 3 selects the control word.
- `din` input 8: write data.
- `current_count` input 16: live count from the mode unit.
- `dout` output 8: read data, registered.
- `countreg` output 16: assembled count to the mode unit.
- `new_count` output 1: one-cycle pulse when `countreg` is fully written.
- `mode` output 3: programmed mode 0-5.
- `bcd` output 1: BCD flag from control word.
- `count_pending` output 1: high from control word until the first complete count write.

## Operation
- Bus access is qualified as `cs & wr` (write) or `cs & rd` (read). `wr` and `rd` in the same cycle: the write executes and the read is ignored.
- Control word (write, `a`=3), accepted only if `din[7:6]`==`COUNTER_ID`; SC=3 (read-back) is ignored by this block:
  - RW=`din[5:4]`=00: counter latch command. If not already latched, capture `current_count` into the output latch and set `latched`. If already latched, the command is ignored.
  - RW≠00: store RW, `mode`=`din[3:1]` (6→2, 7→3), `bcd`=`din[0]`. Reset write and read byte pointers to LSB, clear `latched`, set `count_pending`. `countreg` is unchanged.
- Count write (`a`=`COUNTER_ID`):
  - RW=01: `countreg`={8'h00,`din`}, pulse `new_count`.
  - RW=10: `countreg`={`din`,8'h00}, pulse `new_count`.
  - RW=11: first write stores `din` in the LSB holding register and moves the pointer to MSB. Second write sets `countreg`={`din`,hold}, pulses `new_count`, and returns the pointer to LSB. A control word between the two writes discards the held LSB.
  - Each `new_count` pulse clears `count_pending`. A value of 0 is passed through unchanged; the mode unit interprets it.
- Count read (`a`=`COUNTER_ID`): the source is the latch if `latched`, otherwise `current_count`.
  - RW=01: returns LSB. RW=10: returns MSB.
  - RW=11: returns LSB, then MSB, toggling the read pointer.
  - `latched` clears after the last byte of the sequence is read: after the single byte for RW=01/10, after the MSB for RW=11.
- Accesses with `a`=0-2 not equal to `COUNTER_ID` have no effect. `dout` holds its value when no read occurs.

## Timing
- Reset (async assert, sync to `clk` on deassert):
  - `countreg`=0, `new_count`=0, `dout`=0, `mode`=0, `bcd`=0, `count_pending`=0.
  - RW=11, both byte pointers at LSB, `latched`=0, hold=0.
- Write committed on the rising edge where `cs & wr`. `countreg` is valid after that edge. `new_count` is high for exactly the following cycle.
- Latch command captures `current_count` as sampled on the command edge.
- Read: `dout` updates on the edge where `cs & rd` and is valid the following cycle. Pointer and latch state update on the same edge.
- Back-to-back accesses every cycle are supported with no stall.
- Reset asserted mid-sequence (LSB held, or latch pending) discards all partial state immediately.

## Test plan
- Reset, then control word 8'h12 (SC0, RW=01, mode1), write 8'h04 to `a`=0. Required: `countreg`=16'h0004, one-cycle `new_count`, `mode`=1, `count_pending` rises after the control word and falls with `new_count`.
- Control word 8'h30 (RW=11, mode0), write 8'h34 then 8'h12. Required: no `new_count` after the first write; after the second, `countreg`=16'h1234 and a single pulse.
- With `current_count`=16'hABCD, send latch command 8'h00, change `current_count` to 16'h0001, then read twice. Required: `dout`=8'hCD, then 8'hAB. A third read returns the live value 8'h01.
- With `COUNTER_ID`=1: control word 8'h12 and a write to `a`=0. Required: `mode`, `countreg` and `count_pending` unchanged, and no `new_count`.
- RW=11: write LSB 8'hFF, assert `rst_n`=0 mid-cycle, release, then write 8'h05, 8'h00. Required: all outputs 0 immediately on reset; afterwards `countreg`=16'h0005.
- Same-cycle `wr`+`rd` to `a`=0 with RW=01, `din`=8'h07. Required: `countreg`=16'h0007, `dout` unchanged.
